// File: rtl/mips_pkg.sv
// Shared fetch-stage types and constants for the MIPS datapath slice.
package mips_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    FETCH_IDLE     = 2'b00,
    FETCH_RUN      = 2'b01,
    FETCH_REDIRECT = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/mips_imem.sv
// Word-addressed instruction memory: asynchronous read, synchronous write.
module mips_imem
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [DEPTH];

  // A same-cycle write lands after the edge, so the reader sees the old word.
  assign rdata = mem[raddr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/mips_fetch_unit.sv
// Fetch stage: PC, instruction memory, stall and 2-bubble branch redirect.
// Optional FETCH_PERF_CNT_EN adds saturating fetch/bubble counters.
module mips_fetch_unit
  import mips_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 64,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  localparam int unsigned AW        = $clog2(IMEM_DEPTH)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               Stall,
  input  logic               Branch_Taken,
  input  logic [31:0]        Branch_Target,
  input  logic               IMem_We,
  input  logic [AW-1:0]      IMem_Waddr,
  input  logic [INSTR_W-1:0] IMem_Wdata,
  output logic [INSTR_W-1:0] Instruction,
  output logic [31:0]        PC_Out,
  output logic               Instr_Valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        Fetch_Count,
  output logic [31:0]        Bubble_Count
`endif
);

  fetch_state_e       state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        pc_out_q, pc_out_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] rdata;

  mips_imem #(
    .DEPTH (IMEM_DEPTH)
  ) u_imem (
    .clk   (CLK),
    .we    (IMem_We),
    .waddr (IMem_Waddr),
    .wdata (IMem_Wdata),
    .raddr (pc_q[AW+1:2]),
    .rdata (rdata)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pc_out_d = pc_out_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    if (Branch_Taken) begin
      pc_d    = {Branch_Target[31:2], 2'b00};
      instr_d = NOP;
      valid_d = 1'b0;
      state_d = FETCH_REDIRECT;
    end else begin
      case (state_q)
        FETCH_IDLE, FETCH_REDIRECT: begin
          // Bubble cycles advance regardless of Stall.
          instr_d = NOP;
          valid_d = 1'b0;
          state_d = FETCH_RUN;
        end
        FETCH_RUN: begin
          if (!Stall) begin
            instr_d  = rdata;
            pc_out_d = pc_q;
            valid_d  = 1'b1;
            pc_d     = pc_q + PC_STEP;
          end
        end
        default: state_d = FETCH_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= FETCH_IDLE;
      pc_q     <= RESET_PC;
      pc_out_q <= 32'h0;
      instr_q  <= NOP;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_out_q <= pc_out_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
    end
  end

  assign Instruction = instr_q;
  assign PC_Out      = pc_out_q;
  assign Instr_Valid = valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, bubble_cnt_q;
  logic        fetch_evt, bubble_evt;

  assign fetch_evt  = !Branch_Taken && (state_q == FETCH_RUN) && !Stall;
  assign bubble_evt = Branch_Taken || (state_q != FETCH_RUN);

  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_cnt_q  <= 32'h0;
      bubble_cnt_q <= 32'h0;
    end else begin
      if (fetch_evt && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (bubble_evt && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end
    end
  end

  assign Fetch_Count  = fetch_cnt_q;
  assign Bubble_Count = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed self-checking bench for mips_fetch_unit.
module tb_mips_fetch_unit;

  logic        CLK;
  logic        RST;
  logic        Stall;
  logic        Branch_Taken;
  logic [31:0] Branch_Target;
  logic        IMem_We;
  logic [5:0]  IMem_Waddr;
  logic [31:0] IMem_Wdata;
  logic [31:0] Instruction;
  logic [31:0] PC_Out;
  logic        Instr_Valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] Fetch_Count;
  logic [31:0] Bubble_Count;
`endif

  int vectors;
  int miscompares;

  mips_fetch_unit #(
    .IMEM_DEPTH (64),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .Stall         (Stall),
    .Branch_Taken  (Branch_Taken),
    .Branch_Target (Branch_Target),
    .IMem_We       (IMem_We),
    .IMem_Waddr    (IMem_Waddr),
    .IMem_Wdata    (IMem_Wdata),
    .Instruction   (Instruction),
    .PC_Out        (PC_Out),
    .Instr_Valid   (Instr_Valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .Fetch_Count   (Fetch_Count),
    .Bubble_Count  (Bubble_Count)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one rising edge and settle before sampling.
  task tick();
    @(posedge CLK);
    #1;
  endtask

  task load(input logic [5:0] idx, input logic [31:0] data);
    IMem_We    = 1'b1;
    IMem_Waddr = idx;
    IMem_Wdata = data;
    tick();
    IMem_We    = 1'b0;
  endtask

  task do_reset();
    RST          = 1'b1;
    Stall        = 1'b0;
    Branch_Taken = 1'b0;
    tick();
    RST          = 1'b0;
  endtask

  task test_reset();
    do_reset();
    vectors++;
    if ({Instr_Valid, PC_Out, Instruction} !== 65'h0) begin
      miscompares++;
      $display("FAIL reset: got v=%b pc=%h ins=%h want 0/0/0", Instr_Valid, PC_Out, Instruction);
    end
  endtask

  task test_sequence();
    logic [31:0] exp_ins [4];
    exp_ins[0] = 32'h0C00A020; exp_ins[1] = 32'h0E80A020;
    exp_ins[2] = 32'h02B49820; exp_ins[3] = 32'h0693B020;
    do_reset();
    tick();
    vectors++;
    if ({Instr_Valid, Instruction} !== 33'h0) begin
      miscompares++;
      $display("FAIL seq_bubble: got v=%b ins=%h want 0/0", Instr_Valid, Instruction);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if ({Instr_Valid, PC_Out, Instruction} !== {1'b1, 32'(i * 4), exp_ins[i]}) begin
        miscompares++;
        $display("FAIL seq_%0d: got v=%b pc=%h ins=%h want 1/%h/%h", i, Instr_Valid, PC_Out,
                 Instruction, 32'(i * 4), exp_ins[i]);
      end
    end
`ifdef FETCH_PERF_CNT_EN
    vectors++;
    if ({Fetch_Count, Bubble_Count} !== {32'd4, 32'd1}) begin
      miscompares++;
      $display("FAIL perf_cnt: got fetch=%0d bubble=%0d want 4/1", Fetch_Count, Bubble_Count);
    end
`endif
  endtask

  task test_stall();
    do_reset();
    tick(); tick(); tick();
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({Instr_Valid, PC_Out, Instruction} !== {1'b1, 32'h4, 32'h0E80A020}) begin
        miscompares++;
        $display("FAIL stall_hold_%0d: got v=%b pc=%h ins=%h want 1/4/0e80a020", i,
                 Instr_Valid, PC_Out, Instruction);
      end
    end
    Stall = 1'b0;
    tick();
    vectors++;
    if ({Instr_Valid, PC_Out, Instruction} !== {1'b1, 32'h8, 32'h02B49820}) begin
      miscompares++;
      $display("FAIL stall_resume: got v=%b pc=%h ins=%h want 1/8/02b49820", Instr_Valid,
               PC_Out, Instruction);
    end
  endtask

  task test_branch();
    do_reset();
    tick(); tick(); tick();
    Branch_Taken  = 1'b1;
    Branch_Target = 32'h0000_0006;
    tick();
    Branch_Taken  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if ({Instr_Valid, Instruction} !== 33'h0) begin
        miscompares++;
        $display("FAIL branch_bubble_%0d: got v=%b ins=%h want 0/0", i, Instr_Valid, Instruction);
      end
      if (i == 0) tick();
    end
    tick();
    vectors++;
    if ({Instr_Valid, PC_Out, Instruction} !== {1'b1, 32'h4, 32'h0E80A020}) begin
      miscompares++;
      $display("FAIL branch_target: got v=%b pc=%h ins=%h want 1/4/0e80a020", Instr_Valid,
               PC_Out, Instruction);
    end
  endtask

  task test_branch_stall();
    do_reset();
    tick(); tick();
    Stall         = 1'b1;
    Branch_Taken  = 1'b1;
    Branch_Target = 32'h0000_000C;
    tick();
    vectors++;
    if ({Instr_Valid, Instruction} !== 33'h0) begin
      miscompares++;
      $display("FAIL brstall_squash: got v=%b ins=%h want 0/0", Instr_Valid, Instruction);
    end
    Branch_Target = 32'h0000_0008;
    tick();
    Branch_Taken  = 1'b0;
    tick();
    vectors++;
    if ({Instr_Valid, Instruction} !== 33'h0) begin
      miscompares++;
      $display("FAIL brstall_rebubble: got v=%b ins=%h want 0/0", Instr_Valid, Instruction);
    end
    Stall = 1'b0;
    tick();
    vectors++;
    if ({Instr_Valid, PC_Out, Instruction} !== {1'b1, 32'h8, 32'h02B49820}) begin
      miscompares++;
      $display("FAIL brstall_target: got v=%b pc=%h ins=%h want 1/8/02b49820", Instr_Valid,
               PC_Out, Instruction);
    end
  endtask

  task test_wrap();
    logic [31:0] tgt [2];
    logic [31:0] nxt [2];
    tgt[0] = 32'h0000_00FC; nxt[0] = 32'h0000_0100;
    tgt[1] = 32'hFFFF_FFFC; nxt[1] = 32'h0000_0000;
    for (int k = 0; k < 2; k++) begin
      do_reset();
      tick();
      Branch_Taken  = 1'b1;
      Branch_Target = tgt[k];
      tick();
      Branch_Taken  = 1'b0;
      tick(); tick();
      vectors++;
      if ({Instr_Valid, PC_Out, Instruction} !== {1'b1, tgt[k], 32'hDEADBEEF}) begin
        miscompares++;
        $display("FAIL wrap_last_%0d: got v=%b pc=%h ins=%h want 1/%h/deadbeef", k,
                 Instr_Valid, PC_Out, Instruction, tgt[k]);
      end
      tick();
      vectors++;
      if ({Instr_Valid, PC_Out, Instruction} !== {1'b1, nxt[k], 32'h0C00A020}) begin
        miscompares++;
        $display("FAIL wrap_alias_%0d: got v=%b pc=%h ins=%h want 1/%h/0c00a020", k,
                 Instr_Valid, PC_Out, Instruction, nxt[k]);
      end
    end
  endtask

  task test_collision();
    do_reset();
    tick();
    IMem_We    = 1'b1;
    IMem_Waddr = 6'd0;
    IMem_Wdata = 32'h1234_5678;
    tick();
    IMem_We    = 1'b0;
    vectors++;
    if ({Instr_Valid, PC_Out, Instruction} !== {1'b1, 32'h0, 32'h0C00A020}) begin
      miscompares++;
      $display("FAIL collide_old: got v=%b pc=%h ins=%h want 1/0/0c00a020", Instr_Valid,
               PC_Out, Instruction);
    end
    Branch_Taken  = 1'b1;
    Branch_Target = 32'h0;
    tick();
    Branch_Taken  = 1'b0;
    tick(); tick();
    vectors++;
    if ({Instr_Valid, PC_Out, Instruction} !== {1'b1, 32'h0, 32'h1234_5678}) begin
      miscompares++;
      $display("FAIL collide_new: got v=%b pc=%h ins=%h want 1/0/12345678", Instr_Valid,
               PC_Out, Instruction);
    end
    load(6'd0, 32'h0C00A020);
  endtask

  task test_reset_mid_redirect();
    do_reset();
    tick(); tick();
    Branch_Taken  = 1'b1;
    Branch_Target = 32'h0000_0008;
    tick();
    Branch_Taken  = 1'b0;
    RST           = 1'b1;
    tick();
    RST           = 1'b0;
    vectors++;
    if ({Instr_Valid, PC_Out, Instruction} !== 65'h0) begin
      miscompares++;
      $display("FAIL rst_redirect: got v=%b pc=%h ins=%h want 0/0/0", Instr_Valid, PC_Out,
               Instruction);
    end
    tick();
    vectors++;
    if ({Instr_Valid, Instruction} !== 33'h0) begin
      miscompares++;
      $display("FAIL rst_idle_bubble: got v=%b ins=%h want 0/0", Instr_Valid, Instruction);
    end
    tick(); tick();
    RST           = 1'b1;
    Branch_Taken  = 1'b1;
    Branch_Target = 32'h0000_0040;
    tick();
    RST           = 1'b0;
    Branch_Taken  = 1'b0;
    tick(); tick();
    vectors++;
    if ({Instr_Valid, PC_Out, Instruction} !== {1'b1, 32'h0, 32'h0C00A020}) begin
      miscompares++;
      $display("FAIL rst_vs_branch: got v=%b pc=%h ins=%h want 1/0/0c00a020", Instr_Valid,
               PC_Out, Instruction);
    end
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    RST           = 1'b1;
    Stall         = 1'b0;
    Branch_Taken  = 1'b0;
    Branch_Target = 32'h0;
    IMem_We       = 1'b0;
    IMem_Waddr    = 6'd0;
    IMem_Wdata    = 32'h0;
    load(6'd0, 32'h0C00A020);
    load(6'd1, 32'h0E80A020);
    load(6'd2, 32'h02B49820);
    load(6'd3, 32'h0693B020);
    load(6'd63, 32'hDEADBEEF);
    test_reset();
    test_sequence();
    test_stall();
    test_branch();
    test_branch_stall();
    test_wrap();
    test_collision();
    test_reset_mid_redirect();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
